exec_scheduler: RTL and testbench

- Execute-stage controller; sits between the decode/issue register and writeback, and owns the shared combinational ALU.
- Drives the ALU's opcode, funct7, funct3 and operand inputs for every operation.
- Single-cycle ops (ADD/SUB/OR/AND/ADDI, branch/jump/load/store address) complete one cycle after issue.
- MUL (funct7 = MUL_FUNCT7 under OPCODE_ALU) is delayed through a MUL_LATENCY pipeline.
- Completion is in order, through one registered valid/ready writeback port.

---
 rtl/exec_pkg.sv | 37 +++
 rtl/exec_scheduler_if.sv | 34 +++
 rtl/mul_delay_pipe.sv | 42 ++++
 rtl/exec_scheduler.sv | 114 +++++++++++
 tb/tb_exec_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types, constants and decode helper for the execute-stage scheduler.
// The build may predefine the `WORD_SIZE, `OPCODE_ALU and `MUL_FUNCT7 macros.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU 7'h33
`endif
`ifndef MUL_FUNCT7
`define MUL_FUNCT7 7'h01
`endif

package exec_pkg;
  localparam int         WORD_SIZE_DEF   = `WORD_SIZE;
  localparam int         REG_W_DEF       = 5;
  localparam int         MAX_MUL_LATENCY = 8;
  localparam logic [6:0] OPCODE_ALU      = `OPCODE_ALU;
  localparam logic [6:0] MUL_FUNCT7      = `MUL_FUNCT7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    WB_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_W_DEF-1:0]     rd;
    logic [WORD_SIZE_DEF-1:0] data;
    logic                     zero;
    logic [WORD_SIZE_DEF-1:0] exc;
  } stage_t;

  function automatic logic is_mul(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_ALU) && (funct7 == MUL_FUNCT7);
  endfunction
endpackage

// File: rtl/exec_scheduler_if.sv
// Issue and writeback handshake bundle of the execute stage.
// master = decode/writeback side, slave = exec_scheduler.
interface exec_scheduler_if
  import exec_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_W     = REG_W_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_opcode;
  logic [6:0]           in_funct7;
  logic [2:0]           in_funct3;
  logic [WORD_SIZE-1:0] in_op1;
  logic [WORD_SIZE-1:0] in_op2;
  logic [REG_W-1:0]     in_rd;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [REG_W-1:0]     wb_rd;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 wb_zero;
  logic [WORD_SIZE-1:0] wb_exc;

  modport master (
    output in_valid, in_opcode, in_funct7, in_funct3, in_op1, in_op2, in_rd, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_zero, wb_exc
  );

  modport slave (
    input  in_valid, in_opcode, in_funct7, in_funct3, in_op1, in_op2, in_rd, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data, wb_zero, wb_exc
  );
endinterface

// File: rtl/mul_delay_pipe.sv
// Shift register of captured MUL results; en advances, clr kills every stage.
// busy_next predicts occupancy after the coming edge for the scheduler FSM.
module mul_delay_pipe
  import exec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  stage_t d,
  output stage_t q,
  output logic   busy,
  output logic   busy_next
);
  stage_t [DEPTH-1:0] stages;

  // NOTE: the stage array is small, so every field is reset, not just valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stages[i].valid <= 1'b0;
    end else if (en) begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  // NOTE: outputs get a default before any conditional update, so no latch.
  always_comb begin
    busy      = 1'b0;
    busy_next = d.valid;
    for (int i = 0; i < DEPTH; i++)     busy      = busy | stages[i].valid;
    for (int i = 0; i < DEPTH - 1; i++) busy_next = busy_next | stages[i].valid;
    if (!en) busy_next = busy;
    if (clr) busy_next = 1'b0;
  end

  assign q = stages[DEPTH-1];
endmodule

// File: rtl/exec_scheduler.sv
// Execute-stage scheduler: drives the shared ALU, delays MULs, completes in order.
// Define EXEC_SCHED_PERF_EN to add saturating stall/MUL/hold performance counters.
module exec_scheduler
  import exec_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MUL_LATENCY = 5,
  parameter int REG_W       = REG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  exec_scheduler_if.slave      bus,
  output logic [6:0]           alu_opcode,
  output logic [6:0]           alu_funct7,
  output logic [2:0]           alu_funct3,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_zero,
  input  logic [WORD_SIZE-1:0] alu_exc
`ifdef EXEC_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_mul_count,
  output logic [31:0]          perf_hold_cycles
`endif
);
  // The wb register is the final MUL stage, so the pipe holds one stage fewer.
  localparam int PIPE_DEPTH = (MUL_LATENCY < 2)               ? 1 :
                              (MUL_LATENCY > MAX_MUL_LATENCY) ? MAX_MUL_LATENCY - 1 :
                                                                MUL_LATENCY - 1;

  state_t state;
  stage_t sample, pipe_d, pipe_q, wb_q;
  logic   advance, mul_op, in_ready_c, accept, mul_busy, mul_busy_next;

  assign alu_opcode = bus.in_opcode;
  assign alu_funct7 = bus.in_funct7;
  assign alu_funct3 = bus.in_funct3;
  assign alu_in1    = bus.in_op1;
  assign alu_in2    = bus.in_op2;

  assign advance    = !wb_q.valid || bus.wb_ready;
  assign mul_op     = is_mul(bus.in_opcode, bus.in_funct7);
  // A non-MUL waits for the pipe to drain so results never overtake a MUL.
  assign in_ready_c = advance && !flush && !(!mul_op && mul_busy);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    sample.valid = 1'b1;
    sample.rd    = bus.in_rd;
    sample.data  = alu_out;
    sample.zero  = alu_zero;
    sample.exc   = alu_exc;
    pipe_d       = sample;
    pipe_d.valid = accept && mul_op;
  end

  mul_delay_pipe #(.DEPTH(PIPE_DEPTH)) u_mul_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (advance),
    .clr       (flush),
    .d         (pipe_d),
    .q         (pipe_q),
    .busy      (mul_busy),
    .busy_next (mul_busy_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q  <= '0;
      state <= IDLE;
    end else if (flush) begin
      wb_q.valid <= 1'b0;
      state      <= IDLE;
    end else begin
      if (advance) begin
        if (pipe_q.valid)          wb_q       <= pipe_q;
        else if (accept && !mul_op) wb_q       <= sample;
        else                        wb_q.valid <= 1'b0;
      end
      if (!advance)           state <= WB_HOLD;
      else if (mul_busy_next) state <= MUL_BUSY;
      else                    state <= IDLE;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.wb_valid = wb_q.valid;
  assign bus.wb_rd    = wb_q.rd;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_zero  = wb_q.zero;
  assign bus.wb_exc   = wb_q.exc;

`ifdef EXEC_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_mul_count    <= '0;
      perf_hold_cycles  <= '0;
    end else begin
      if (bus.in_valid && !in_ready_c) perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (accept && mul_op)            perf_mul_count    <= sat_inc(perf_mul_count);
      if (state == WB_HOLD)            perf_hold_cycles  <= sat_inc(perf_hold_cycles);
    end
  end
`endif
endmodule

// File: tb/tb_exec_scheduler.sv
// Directed bench for exec_scheduler with a behavioural ALU model.
// Single-cycle ops are table-driven; MUL, backpressure, flush and reset are sequences.
module tb_exec_scheduler;
  import exec_pkg::*;

  localparam int         WS      = 32;
  localparam int         RW      = 5;
  localparam logic [6:0] OP_ALU  = 7'h33;
  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_BAD  = 7'h7F;
  localparam logic [6:0] F7_MUL  = 7'h01;
  localparam logic [6:0] F7_SUB  = 7'h20;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [6:0]    alu_opcode, alu_funct7;
  logic [2:0]    alu_funct3;
  logic [WS-1:0] alu_in1, alu_in2, alu_out, alu_exc;
  logic          alu_zero;
`ifdef EXEC_SCHED_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_mul_count, perf_hold_cycles;
  logic [31:0]   base;
`endif

  exec_scheduler_if #(.WORD_SIZE(WS), .REG_W(RW)) bus ();

  exec_scheduler #(.WORD_SIZE(WS), .MUL_LATENCY(5), .REG_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_funct7 (alu_funct7),
    .alu_funct3 (alu_funct3),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_exc    (alu_exc)
`ifdef EXEC_SCHED_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_mul_count    (perf_mul_count),
    .perf_hold_cycles  (perf_hold_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: R-type ADD/SUB/OR/AND/MUL, address-style ops add, anything else traps.
  always_comb begin
    alu_out  = '0;
    alu_exc  = '0;
    alu_zero = (alu_in1 == alu_in2);
    case (alu_opcode)
      7'h33: begin
        if (alu_funct7 == F7_MUL) alu_out = alu_in1 * alu_in2;
        else begin
          case (alu_funct3)
            3'd0:    alu_out = (alu_funct7 == F7_SUB) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
            3'd6:    alu_out = alu_in1 | alu_in2;
            3'd7:    alu_out = alu_in1 & alu_in2;
            default: alu_exc = 32'd1;
          endcase
        end
      end
      7'h13, 7'h03, 7'h23, 7'h63, 7'h6F: alu_out = alu_in1 + alu_in2;
      default: alu_exc = 32'd1;
    endcase
  end

  typedef struct {
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero;
    logic [31:0] exc;
  } vec_t;

  vec_t vec [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_funct7 = f7;
    bus.in_funct3 = f3;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_rd     = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string name, input logic [31:0] data, input logic [4:0] rd);
    check({name, " wb_valid"}, bus.wb_valid, 1'b1);
    check({name, " wb_data"},  bus.wb_data,  data);
    check({name, " wb_rd"},    bus.wb_rd,    rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{OP_ALU,  7'h00,  3'd0, 32'd7,          32'd5,          5'd3,  32'd12,         1'b0, 32'd0};
    vec[1] = '{OP_ALU,  F7_SUB, 3'd0, 32'd9,          32'd4,          5'd6,  32'd5,          1'b0, 32'd0};
    vec[2] = '{OP_ALU,  7'h00,  3'd6, 32'h0000_00F0,  32'h0000_000F,  5'd1,  32'h0000_00FF,  1'b0, 32'd0};
    vec[3] = '{OP_ALU,  7'h00,  3'd7, 32'h0000_00FF,  32'h0000_003C,  5'd2,  32'h0000_003C,  1'b0, 32'd0};
    vec[4] = '{OP_ADDI, 7'h00,  3'd0, 32'hFFFF_FFFF,  32'd1,          5'd7,  32'd0,          1'b0, 32'd0};
    vec[5] = '{OP_BR,   7'h00,  3'd0, 32'd5,          32'd5,          5'd8,  32'd10,         1'b1, 32'd0};
    vec[6] = '{OP_BAD,  7'h00,  3'd0, 32'd3,          32'd4,          5'd9,  32'd0,          1'b0, 32'd1};
    vec[7] = '{OP_ALU,  F7_SUB, 3'd0, 32'd3,          32'd3,          5'd10, 32'd0,          1'b1, 32'd0};

    issue(7'h00, 7'h00, 3'd0, 32'd0, 32'd0, 5'd0);
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset wb_valid", bus.wb_valid, 1'b0);
    check("reset wb_data",  bus.wb_data,  32'd0);
    check("reset wb_rd",    bus.wb_rd,    5'd0);
    check("reset wb_zero",  bus.wb_zero,  1'b0);
    check("reset wb_exc",   bus.wb_exc,   32'd0);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset state",    dut.state,    IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-cycle ops: accept in cycle N, result in cycle N+1
    for (int i = 0; i < 8; i++) begin
      issue(vec[i].op, vec[i].f7, vec[i].f3, vec[i].a, vec[i].b, vec[i].rd);
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), bus.in_ready, 1'b1);
      check($sformatf("vec%0d alu_in1", i),  alu_in1,      vec[i].a);
      check($sformatf("vec%0d alu_in2", i),  alu_in2,      vec[i].b);
      next_cycle();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_wb($sformatf("vec%0d", i), vec[i].data, vec[i].rd);
      check($sformatf("vec%0d wb_zero", i), bus.wb_zero, vec[i].zero);
      check($sformatf("vec%0d wb_exc", i),  bus.wb_exc,  vec[i].exc);
      next_cycle();
    end
    @(negedge clk);
    check("table drain wb_valid", bus.wb_valid, 1'b0);
    next_cycle();

    // Back-to-back MULs: results in cycles 5 and 6
`ifdef EXEC_SCHED_PERF_EN
    base = perf_mul_count;
`endif
    issue(OP_ALU, F7_MUL, 3'd0, 32'd6, 32'd7, 5'd4);
    @(negedge clk);
    check("mul2 c0 in_ready", bus.in_ready, 1'b1);
    next_cycle();
    issue(OP_ALU, F7_MUL, 3'd0, 32'd3, 32'd3, 5'd5);
    @(negedge clk);
    check("mul2 c1 in_ready", bus.in_ready, 1'b1);
    next_cycle();
    bus.in_valid = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("mul2 c%0d wb_valid", c), bus.wb_valid, 1'b0);
      check($sformatf("mul2 c%0d in_ready", c), bus.in_ready, 1'b1);
      if (c == 2) check("mul2 c2 state", dut.state, MUL_BUSY);
      next_cycle();
    end
    @(negedge clk);
    check_wb("mul2 c5", 32'd42, 5'd4);
    next_cycle();
    @(negedge clk);
    check_wb("mul2 c6", 32'd9, 5'd5);
    next_cycle();
    @(negedge clk);
    check("mul2 c7 wb_valid", bus.wb_valid, 1'b0);
    check("mul2 c7 state",    dut.state,    IDLE);
`ifdef EXEC_SCHED_PERF_EN
    check("perf_mul_count delta", perf_mul_count - base, 32'd2);
`endif
    next_cycle();

    // MUL followed by SUB: SUB stalls cycles 1-4, accepted in 5
`ifdef EXEC_SCHED_PERF_EN
    base = perf_stall_cycles;
`endif
    issue(OP_ALU, F7_MUL, 3'd0, 32'd2, 32'd2, 5'd11);
    @(negedge clk);
    check("stall c0 in_ready", bus.in_ready, 1'b1);
    next_cycle();
    issue(OP_ALU, F7_SUB, 3'd0, 32'd9, 32'd4, 5'd12);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("stall c%0d in_ready", c), bus.in_ready, 1'b0);
      check($sformatf("stall c%0d wb_valid", c), bus.wb_valid, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check("stall c5 in_ready", bus.in_ready, 1'b1);
    check_wb("stall c5", 32'd4, 5'd11);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_wb("stall c6", 32'd5, 5'd12);
    next_cycle();
    @(negedge clk);
    check("stall c7 wb_valid", bus.wb_valid, 1'b0);
`ifdef EXEC_SCHED_PERF_EN
    check("perf_stall_cycles delta", perf_stall_cycles - base, 32'd4);
`endif
    next_cycle();

    // Writeback backpressure for three cycles
`ifdef EXEC_SCHED_PERF_EN
    base = perf_hold_cycles;
`endif
    issue(OP_ALU, 7'h00, 3'd0, 32'd1, 32'd1, 5'd13);
    next_cycle();
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_wb($sformatf("hold c%0d", c), 32'd2, 5'd13);
      check($sformatf("hold c%0d in_ready", c), bus.in_ready, 1'b0);
      if (c >= 2) check($sformatf("hold c%0d state", c), dut.state, WB_HOLD);
      next_cycle();
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check_wb("hold c4", 32'd2, 5'd13);
    next_cycle();
    @(negedge clk);
    check("hold c5 wb_valid", bus.wb_valid, 1'b0);
    check("hold c5 state",    dut.state,    IDLE);
`ifdef EXEC_SCHED_PERF_EN
    check("perf_hold_cycles delta", perf_hold_cycles - base, 32'd3);
`endif
    next_cycle();

    // Flush with two MULs in flight, then a fresh ADD
    issue(OP_ALU, F7_MUL, 3'd0, 32'd6, 32'd7, 5'd14);
    next_cycle();
    issue(OP_ALU, F7_MUL, 3'd0, 32'd3, 32'd3, 5'd15);
    next_cycle();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush c2 in_ready", bus.in_ready, 1'b0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flush c3 wb_valid", bus.wb_valid, 1'b0);
    check("flush c3 state",    dut.state,    IDLE);
    issue(OP_ALU, 7'h00, 3'd0, 32'd1, 32'd2, 5'd16);
    #1;
    check("flush c3 in_ready", bus.in_ready, 1'b1);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_wb("flush c4", 32'd3, 5'd16);
    next_cycle();
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("flush c%0d wb_valid", c), bus.wb_valid, 1'b0);
      next_cycle();
    end

    // Flush discards a result held by backpressure
    issue(OP_ALU, 7'h00, 3'd0, 32'd4, 32'd4, 5'd17);
    next_cycle();
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b0;
    @(negedge clk);
    check_wb("flushhold c1", 32'd8, 5'd17);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flushhold c2 wb_valid", bus.wb_valid, 1'b0);
    bus.wb_ready = 1'b1;
    next_cycle();

    // Reset in the middle of a MUL drops it
    issue(OP_ALU, F7_MUL, 3'd0, 32'd5, 32'd5, 5'd18);
    next_cycle();
    bus.in_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("midrst state",    dut.state,    IDLE);
    check("midrst in_ready", bus.in_ready, 1'b1);
`ifdef EXEC_SCHED_PERF_EN
    check("midrst perf_mul_count", perf_mul_count, 32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("midrst c%0d wb_valid", c), bus.wb_valid, 1'b0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
